// File: rtl/color_entry_collector.sv
// color_entry_collector: assembles NUM_CH x DIGITS_PER_CH strobed keypad digits into one committed word.
// Define COLOR_ENTRY_BACKSPACE_EN to make the backspace input remove the last entered digit.
module color_entry_collector #(
  parameter  int DIGIT_W        = 4,
  parameter  int DIGITS_PER_CH  = 2,
  parameter  int NUM_CH         = 3,
  parameter  int TIMEOUT_CYCLES = 0,
  localparam int TOTAL_DIGITS   = NUM_CH * DIGITS_PER_CH,
  localparam int TOTAL_W        = TOTAL_DIGITS * DIGIT_W,
  localparam int CNT_W          = $clog2(TOTAL_DIGITS + 1),
  localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               digit_valid,
  input  logic [DIGIT_W-1:0] digit,
  input  logic               cancel,
  input  logic               backspace,
  output logic [TOTAL_W-1:0] color,
  output logic [TOTAL_W-1:0] pending,
  output logic [CNT_W-1:0]   digit_count,
  output logic [CH_W-1:0]    channel_idx,
  output logic               busy,
  output logic               done,
  output logic               timeout
);

  localparam int TO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic {IDLE, ENTRY} state_t;

  state_t             state, state_nxt;
  logic [TOTAL_W-1:0] color_nxt, pending_nxt, word;
  logic [CNT_W-1:0]   count_nxt;
  logic [TO_W-1:0]    idle_cnt, idle_nxt;
  logic               done_nxt, timeout_nxt;

`ifndef COLOR_ENTRY_BACKSPACE_EN
  logic unused_backspace;
  assign unused_backspace = backspace;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      color       <= '0;
      pending     <= '0;
      digit_count <= '0;
      idle_cnt    <= '0;
      done        <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_nxt;
      color       <= color_nxt;
      pending     <= pending_nxt;
      digit_count <= count_nxt;
      idle_cnt    <= idle_nxt;
      done        <= done_nxt;
      timeout     <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    color_nxt   = color;
    pending_nxt = pending;
    count_nxt   = digit_count;
    idle_nxt    = '0;
    done_nxt    = 1'b0;
    timeout_nxt = 1'b0;

    // In IDLE pending and digit_count are zero, so the same merge serves the first digit.
    word = pending;
    for (int unsigned k = 0; k < TOTAL_DIGITS; k++)
      if (digit_count == CNT_W'(k))
        word[TOTAL_W-1-k*DIGIT_W -: DIGIT_W] = digit;

    if (cancel) begin
      if (state == ENTRY) begin
        pending_nxt = '0;
        count_nxt   = '0;
        state_nxt   = IDLE;
      end
    end
`ifdef COLOR_ENTRY_BACKSPACE_EN
    else if (backspace) begin
      if (state == ENTRY) begin
        if (digit_count > CNT_W'(1)) begin
          for (int unsigned k = 0; k < TOTAL_DIGITS; k++)
            if (digit_count == CNT_W'(k + 1))
              pending_nxt[TOTAL_W-1-k*DIGIT_W -: DIGIT_W] = '0;
          count_nxt = digit_count - CNT_W'(1);
        end else begin
          pending_nxt = '0;
          count_nxt   = '0;
          state_nxt   = IDLE;
        end
      end
    end
`endif
    else if (digit_valid) begin
      if (digit_count == CNT_W'(TOTAL_DIGITS - 1)) begin
        color_nxt   = word;
        done_nxt    = 1'b1;
        pending_nxt = '0;
        count_nxt   = '0;
        state_nxt   = IDLE;
      end else begin
        pending_nxt = word;
        count_nxt   = digit_count + CNT_W'(1);
        state_nxt   = ENTRY;
      end
    end else if (state == ENTRY && TIMEOUT_CYCLES > 0) begin
      // Abort on the edge that would bring the idle count to TIMEOUT_CYCLES.
      if (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
        pending_nxt = '0;
        count_nxt   = '0;
        state_nxt   = IDLE;
        timeout_nxt = 1'b1;
      end else begin
        idle_nxt = idle_cnt + TO_W'(1);
      end
    end
  end

  assign busy = (state == ENTRY);

  always_comb begin
    int unsigned ch;
    ch = 32'(digit_count) / DIGITS_PER_CH;
    if (ch > NUM_CH - 1)
      ch = NUM_CH - 1;
    channel_idx = CH_W'(ch);
  end

endmodule
